// File: rtl/tage_update.sv
// TAGE training-side writer: base/provider counter update, allocation and useful-bit sweep.
// Optional macro TAGE_PERIODIC_DECAY_EN adds a sweep every DECAY_PERIOD accepted updates.
module tage_update #(
  parameter int NUM_TABLES   = 12,
  parameter int IDX_W        = 11,
  parameter int TAG_W        = 15,
  parameter int CTR_W        = 3,
  parameter int U_W          = 2,
  parameter int TICK_W       = 8,
  parameter int DECAY_PERIOD = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic                        upd_taken,
  input  logic                        upd_pred,
  input  logic                        upd_alt_pred,
  input  logic [3:0]                  upd_provider,
  input  logic [1:0]                  upd_base_ctr,
  input  logic [CTR_W-1:0]            upd_prov_ctr,
  input  logic [U_W-1:0]              upd_prov_u,
  input  logic [NUM_TABLES*IDX_W-1:0] upd_idx,
  input  logic [NUM_TABLES*TAG_W-1:0] upd_tag,
  input  logic [NUM_TABLES*U_W-1:0]   upd_u_vec,
  output logic                        wr_en,
  output logic                        wr_bcast,
  output logic [3:0]                  wr_table,
  output logic [IDX_W-1:0]            wr_idx,
  output logic [TAG_W-1:0]            wr_tag,
  output logic [CTR_W-1:0]            wr_ctr,
  output logic [U_W-1:0]              wr_u,
  output logic                        wr_tag_en,
  output logic                        wr_ctr_en,
  output logic                        wr_u_en
);

  typedef enum logic [1:0] {IDLE = 2'd0, PROV = 2'd1, ALLOC = 2'd2, SWEEP = 2'd3} state_t;

  localparam logic [CTR_W-1:0]  CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0]  CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [TICK_W-1:0] TICK_NEAR   = {{(TICK_W-1){1'b1}}, 1'b0};
  localparam logic [IDX_W-1:0]  IDX_LAST    = {IDX_W{1'b1}};

  function automatic logic [CTR_W-1:0] ctr_sat(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (c == {CTR_W{1'b1}}) ? c : c + CTR_W'(1);
    else    return (c == {CTR_W{1'b0}}) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [1:0] base_sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? c : c + 2'd1;
    else    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [U_W-1:0] u_sat(input logic [U_W-1:0] u, input logic up);
    if (up) return (u == {U_W{1'b1}}) ? u : u + U_W'(1);
    else    return (u == {U_W{1'b0}}) ? u : u - U_W'(1);
  endfunction

  state_t                      state_r;
  logic                        taken_r;
  logic                        pred_r;
  logic [3:0]                  prov_r;
  logic [NUM_TABLES*IDX_W-1:0] idx_r;
  logic [NUM_TABLES*TAG_W-1:0] tag_r;
  logic [NUM_TABLES*U_W-1:0]   u_vec_r;
  logic [TICK_W-1:0]           tick_r;
  logic                        sweep_pend_r;
`ifdef TAGE_PERIODIC_DECAY_EN
  localparam int DC_W = $clog2(DECAY_PERIOD) + 1;
  logic [DC_W-1:0]             upd_cnt_r;
`endif

  logic [3:0]       p_slot_s;
  logic [IDX_W-1:0] p_idx_s;
  logic [CTR_W-1:0] p_ctr_s;
  logic [U_W-1:0]   p_u_s;
  logic             p_u_en_s;
  logic             prov_dir_s;
  logic             a_found_s;
  logic [3:0]       a_slot_s;
  logic             alloc_s;
  logic             leave_s;

  // Provider-write fields from live inputs; allocation search over the registered snapshot.
  always_comb begin
    p_slot_s   = ((upd_provider == 4'd0) || (upd_provider > 4'(NUM_TABLES))) ? 4'd0 : upd_provider - 4'd1;
    p_idx_s    = upd_idx[p_slot_s*IDX_W +: IDX_W];
    prov_dir_s = upd_prov_ctr[CTR_W-1];
    if (upd_provider == 4'd0) begin
      p_ctr_s  = {{(CTR_W-2){1'b0}}, base_sat(upd_base_ctr, upd_taken)};
      p_u_s    = {U_W{1'b0}};
      p_u_en_s = 1'b0;
    end else begin
      p_ctr_s  = ctr_sat(upd_prov_ctr, upd_taken);
      p_u_s    = (prov_dir_s != upd_alt_pred) ? u_sat(upd_prov_u, prov_dir_s == upd_taken) : upd_prov_u;
      p_u_en_s = 1'b1;
    end
    // Scan downward so the lowest qualifying table wins.
    a_found_s = 1'b0;
    a_slot_s  = 4'd0;
    for (int t = NUM_TABLES; t >= 1; t--) begin
      if ((4'(t) > prov_r) && (u_vec_r[(t-1)*U_W +: U_W] == {U_W{1'b0}})) begin
        a_found_s = 1'b1;
        a_slot_s  = 4'(t - 1);
      end else begin
        a_found_s = a_found_s;
        a_slot_s  = a_slot_s;
      end
    end
    alloc_s = (pred_r != taken_r) && (prov_r < 4'(NUM_TABLES));
    leave_s = ((state_r == PROV) && !alloc_s) || (state_r == ALLOC);
  end

  // Update FSM, counters and registered write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      upd_ready    <= 1'b0;
      taken_r      <= 1'b0;
      pred_r       <= 1'b0;
      prov_r       <= 4'd0;
      idx_r        <= '0;
      tag_r        <= '0;
      u_vec_r      <= '0;
      tick_r       <= '0;
      sweep_pend_r <= 1'b0;
      wr_en        <= 1'b0;
      wr_bcast     <= 1'b0;
      wr_table     <= 4'd0;
      wr_idx       <= '0;
      wr_tag       <= '0;
      wr_ctr       <= '0;
      wr_u         <= '0;
      wr_tag_en    <= 1'b0;
      wr_ctr_en    <= 1'b0;
      wr_u_en      <= 1'b0;
`ifdef TAGE_PERIODIC_DECAY_EN
      upd_cnt_r    <= '0;
`endif
    end else begin
      wr_en     <= 1'b0;
      wr_bcast  <= 1'b0;
      wr_table  <= 4'd0;
      wr_idx    <= '0;
      wr_tag    <= '0;
      wr_ctr    <= '0;
      wr_u      <= '0;
      wr_tag_en <= 1'b0;
      wr_ctr_en <= 1'b0;
      wr_u_en   <= 1'b0;
      case (state_r)
        IDLE: begin
          upd_ready <= 1'b1;
          if (upd_valid && upd_ready) begin
            upd_ready <= 1'b0;
            state_r   <= PROV;
            taken_r   <= upd_taken;
            pred_r    <= upd_pred;
            prov_r    <= upd_provider;
            idx_r     <= upd_idx;
            tag_r     <= upd_tag;
            u_vec_r   <= upd_u_vec;
            wr_en     <= 1'b1;
            wr_table  <= upd_provider;
            wr_idx    <= p_idx_s;
            wr_ctr    <= p_ctr_s;
            wr_u      <= p_u_s;
            wr_ctr_en <= 1'b1;
            wr_u_en   <= p_u_en_s;
`ifdef TAGE_PERIODIC_DECAY_EN
            if (upd_cnt_r == DC_W'(DECAY_PERIOD - 1)) begin
              upd_cnt_r    <= '0;
              sweep_pend_r <= 1'b1;
            end else begin
              upd_cnt_r    <= upd_cnt_r + DC_W'(1);
            end
`endif
          end
        end
        PROV: begin
          if (alloc_s) begin
            state_r <= ALLOC;
            if (a_found_s) begin
              wr_en     <= 1'b1;
              wr_table  <= a_slot_s + 4'd1;
              wr_idx    <= idx_r[a_slot_s*IDX_W +: IDX_W];
              wr_tag    <= tag_r[a_slot_s*TAG_W +: TAG_W];
              wr_ctr    <= taken_r ? CTR_WEAK_T : CTR_WEAK_NT;
              wr_tag_en <= 1'b1;
              wr_ctr_en <= 1'b1;
              wr_u_en   <= 1'b1;
              tick_r    <= (tick_r == '0) ? tick_r : tick_r - TICK_W'(1);
            end else if (tick_r == TICK_NEAR) begin
              tick_r       <= '0;
              sweep_pend_r <= 1'b1;
            end else begin
              tick_r       <= tick_r + TICK_W'(1);
            end
          end
        end
        ALLOC: begin
          state_r <= ALLOC;
        end
        SWEEP: begin
          if (wr_idx == IDX_LAST) begin
            state_r      <= IDLE;
            upd_ready    <= 1'b1;
            sweep_pend_r <= 1'b0;
          end else begin
            wr_en    <= 1'b1;
            wr_bcast <= 1'b1;
            wr_u_en  <= 1'b1;
            wr_idx   <= wr_idx + IDX_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // Sweep entry issues index 0 immediately so the sweep spans exactly 2^IDX_W cycles.
      if (leave_s) begin
        if (sweep_pend_r) begin
          state_r  <= SWEEP;
          wr_en    <= 1'b1;
          wr_bcast <= 1'b1;
          wr_u_en  <= 1'b1;
          wr_idx   <= '0;
        end else begin
          state_r   <= IDLE;
          upd_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tage_update.md
# tage_update

Training-side writer for the TAGE predictor. It accepts one resolved-branch update at a time, carrying the prediction-time snapshot of provider, alternate, indices, tags and useful bits. It then issues the table writes: a base or provider counter update, optional allocation in a longer-history table, and a bulk useful-bit clear when allocation pressure saturates. Its write port drives the same T0–T12 BRAMs that the prediction path reads.

## Interface
- NUM_TABLES, 12: tagged tables T1..T12; T0 is the bimodal base.
- IDX_W, 11: table index width; all tables are addressed with IDX_W bits and smaller tables ignore the MSBs.
- TAG_W, 15: widest tag; narrower tables ignore the MSBs.
- CTR_W, 3: tagged prediction counter width.
- U_W, 2: useful counter width.
- TICK_W, 8: allocation-failure counter width.
- DECAY_PERIOD, 1000: accepted updates per periodic decay; used only with the macro.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- upd_valid  in  1  update offered
- upd_ready  out  1  update accepted when high with upd_valid
- upd_taken  in  1  resolved direction
- upd_pred  in  1  final prediction delivered at fetch
- upd_alt_pred  in  1  alternate prediction
- upd_provider  in  4  0 = base, k = Tk
- upd_base_ctr  in  2  T0 counter read at predict time
- upd_prov_ctr  in  CTR_W  provider counter
- upd_prov_u  in  U_W  provider useful bits
- upd_idx  in  NUM_TABLES*IDX_W  per-table index; slice k-1 is Tk, slice 0 is also used for T0
- upd_tag  in  NUM_TABLES*TAG_W  per-table computed tag
- upd_u_vec  in  NUM_TABLES*U_W  per-table useful bits read at predict time
- wr_en  out  1  table write strobe
- wr_bcast  out  1  write applies to all of T1..TNUM_TABLES
- wr_table  out  4  target table
- wr_idx  out  IDX_W  target entry
- wr_tag  out  TAG_W
- wr_ctr  out  CTR_W  T0 uses bits [1:0]
- wr_u  out  U_W
- wr_tag_en, wr_ctr_en, wr_u_en  out  1 each  field enables

## Operation
- States: IDLE, PROV, ALLOC, SWEEP.
- IDLE:
  - upd_ready=1.
  - On upd_valid, all inputs are registered and the FSM goes to PROV.
- PROV: exactly one write.
  - Provider 0: wr_table=0, idx from slice 0, wr_ctr = base counter saturating toward upd_taken, ctr_en only.
  - Provider k>0: ctr saturating toward taken. If the provider prediction (ctr MSB) differs from upd_alt_pred, u increments when the provider was correct and decrements when wrong, both saturating; otherwise u is unchanged. ctr_en and u_en set, tag_en=0.
- Allocation condition: upd_pred != upd_taken and upd_provider < NUM_TABLES.
  - If the condition is false, go to IDLE (or SWEEP, see below).
  - If true, go to ALLOC.
- ALLOC: select the lowest j > provider with u_j==0.
  - Found: write Tj with tag_j and u=0, all enables set. ctr = 2^(CTR_W-1) if taken, else 2^(CTR_W-1)-1. tick decrements, saturating at 0.
  - Not found: wr_en=0 and tick increments.
- Tick saturation: tick reaching all-ones sets sweep_pend and clears tick.
- Leaving PROV or ALLOC with sweep_pend set goes to SWEEP instead of IDLE.
- SWEEP:
  - wr_en=1, wr_bcast=1, u_en only, wr_u=0.
  - wr_idx counts 0..2^IDX_W-1, one per cycle, then returns to IDLE and clears sweep_pend.
- Arithmetic: all counters are saturating unsigned; no wrap.

## Timing
- Accept at cycle N, PROV write at N+1, ALLOC write (if any) at N+2.
- upd_ready returns at N+2 without ALLOC, N+3 with ALLOC.
- SWEEP lasts 2^IDX_W cycles; upd_ready=0 throughout.
- upd_ready is registered. Reset values: upd_ready=0, all wr_* outputs=0, tick=0, sweep_pend=0, state IDLE. upd_ready=1 from the first cycle after reset release.
- Reset mid-operation aborts PROV, ALLOC or SWEEP immediately; partial sweep progress is discarded.
- Outputs are registered; every wr_* field is zero in any cycle where wr_en=0.

## Configuration
- TAGE_PERIODIC_DECAY_EN defined: an update counter increments on each acceptance. On the DECAY_PERIOD-th update it sets sweep_pend and clears itself. A coincident tick saturation still produces a single sweep, and both counters clear.
- Not defined: sweeps are triggered only by tick saturation; the update counter is absent.

## Test plan
- Base update: provider=0, base_ctr=1, taken=1 → cycle N+1: wr_en=1, wr_table=0, wr_ctr=2, only ctr_en; ready at N+2.
- Provider update: provider=3, ctr=3, u=1, taken=0, pred=0, alt=1 → wr_table=3, wr_ctr=2, wr_u=2, tag_en=0; no ALLOC.
- Allocation: provider=2, pred≠taken=1, u_vec T3=1, T4=0 → N+2: wr_table=4, wr_tag=tag slice 3, wr_ctr=4, wr_u=0, all enables set; tick 5→4.
- Allocation failure: provider=11, u T12=3 → no ALLOC write; tick +1. With tick preloaded to 254 → tick saturates and clears; SWEEP writes idx 0..2047 with wr_bcast=1; ready low 2048 cycles.
- Reset asserted at sweep idx 100 → next cycle all outputs 0. After release, ready=1 and no further sweep writes.
- Macro: TAGE_PERIODIC_DECAY_EN with DECAY_PERIOD=4 → four non-allocating updates, sweep starts after the fourth PROV write. Without the macro → no sweep.
